// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding
// and a width helper used for counter and pointer sizing.
package fifo_arb_pkg;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_BURST = 1'b1;

  typedef enum logic {
    IDLE  = STATE_IDLE,
    BURST = STATE_BURST
  } state_t;

  // Smallest r with 2**r >= value; callers always pass value >= 2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after 'last', wrapping around, as a one-hot vector.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  logic          found;
  logic [IW-1:0] idx;

  // Walk last+1 .. last+NREQ so the previous winner is considered last.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters,
// granting whole packets (capped at MAXBURST beats) and honouring FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8,
  parameter int MAXBURST = 4
) (
  input  logic                     i_wr_clk,
  input  logic                     i_wr_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*DATASIZE-1:0] i_req_data,
  input  logic [NREQ-1:0]          i_req_last,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic                     i_full,
  output logic                     o_wr_en,
  output logic [DATASIZE-1:0]      o_wr_data,
  output logic [NREQ-1:0]          o_grant,
  output logic                     o_busy
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(MAXBURST + 1);

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [CW-1:0]   count;
  logic [IW-1:0]   last;
  logic            busy;

  logic [NREQ-1:0] pick;
  logic            any;
  logic [IW-1:0]   pick_idx;
  logic            run;
  logic            gvalid;
  logic            glast;
  logic            xfer;
  logic            burst_done;
  logic [CW-1:0]   count_next;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req (i_req_valid),
    .last(last),
    .pick(pick),
    .any (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  // Ready and write enable stay combinational so a rising full flag or a
  // reset request stops the very next FIFO write.
  assign run        = (state == BURST) && i_wr_rst && !i_full;
  assign gvalid     = |(i_req_valid & grant);
  assign glast      = |(i_req_last & grant);
  assign xfer       = run && gvalid;
  assign count_next = count + 1'b1;
  assign burst_done = glast || (count_next == CW'(MAXBURST));

  assign o_req_ready = grant & {NREQ{run}};
  assign o_wr_en     = xfer;
  assign o_grant     = grant;
  assign o_busy      = busy;

  always_comb begin
    o_wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) o_wr_data = i_req_data[i*DATASIZE +: DATASIZE];
    end
  end

  always_ff @(posedge i_wr_clk) begin
    if (!i_wr_rst) begin
      state <= IDLE;
      grant <= '0;
      count <= '0;
      last  <= IW'(NREQ - 1);
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            grant <= pick;
            count <= '0;
            last  <= pick_idx;
            state <= BURST;
            busy  <= 1'b1;
          end
        end
        BURST: begin
          if (xfer) begin
            if (burst_done) begin
              state <= IDLE;
              grant <= '0;
              count <= '0;
              busy  <= 1'b0;
            end else begin
              count <= count_next;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
